hirose_hash_verifier: RTL and testbench
=======================================

# hirose_hash_verifier

Sequencer on the consumer side of the Hirose/PRESENT hash wrapper interface. It accepts a message block, a 64-bit constant and an expected 128-bit digest through a start/ready handshake, then drives the wrapper's reset, plaintext and constant inputs. It waits for the wrapper's end signal under a watchdog, compares the returned digest slice-by-slice, and reports match/timeout with a one-cycle done pulse. It sits between the system controller and one hash wrapper instance, which is external to this block.

## Interface
Parameters:
- DATA_WIDTH, 64, message block width; must equal the wrapper's DATA_WIDTH and be a multiple of 16.
- TIMEOUT_CYCLES, 1024, maximum number of RUN cycles allowed without hash_end; minimum 2. Counter width is $clog2(TIMEOUT_CYCLES).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  request; sampled only in IDLE.
- msg  in  DATA_WIDTH  message block; captured on an accepted start.
- c_in  in  64  hash constant; captured on an accepted start.
- expected  in  128  reference digest; captured on an accepted start.
- ready  out  1  high exactly when the block is in IDLE.
- hash_rst  out  1  reset to the wrapper.
- hash_plaintext  out  DATA_WIDTH  registered copy of msg.
- hash_c  out  64  registered copy of c_in.
- hash_digest  in  128  wrapper digest, {left, right}.
- hash_end  in  1  wrapper completion; level, held by the wrapper.
- done  out  1  one-cycle completion pulse.
- match  out  1  digest equal to expected; valid from done, held.
- timeout  out  1  watchdog expired; valid from done, held.

## Operation
- States: IDLE, LAUNCH, RUN, COMPARE, REPORT.
- IDLE: ready=1, hash_rst=1. On start=1, capture msg, c_in and expected, clear match and timeout, and go to LAUNCH.
- LAUNCH: one cycle. hash_rst=1, watchdog counter cleared, slice index cleared, diff accumulator cleared. Go to RUN.
- RUN: hash_rst=0.
  - If hash_end=1, go to COMPARE.
  - Otherwise, if counter==TIMEOUT_CYCLES-1, go to REPORT with timeout=1 and match=0.
  - Otherwise, increment the counter.
  - hash_end wins over watchdog expiry in the same cycle.
- COMPARE: hash_rst=0. Once per cycle, OR diff with (hash_digest[16i+15:16i] != expected[16i+15:16i]) for i=0..7, slice 0 first. After i=7, go to REPORT with match = ~diff (including the final slice) and timeout=0.
- REPORT: done=1 for exactly one cycle. Go to IDLE.
- match and timeout change only on entry to REPORT and on an accepted start (cleared). Otherwise they hold.
- start outside IDLE is ignored, with no queuing. hash_plaintext and hash_c do not change until the next accepted start.
- hash_digest is assumed stable while hash_end=1. The wrapper holds its END state because hash_rst stays 0 through COMPARE and REPORT.

## Timing
- Reset values (asynchronous, immediate):
  - Registers and state: state=IDLE, hash_plaintext=0, hash_c=0, match=0, timeout=0, counter=0, diff=0, slice index=0.
  - Outputs: ready=1, hash_rst=1, done=0.
- Reset mid-operation aborts all activity; no done pulse follows.
- ready, hash_rst and done are decoded from state. Start accepted at edge N gives LAUNCH in cycle N+1 and RUN from N+2 (hash_rst falls).
- hash_end sampled at edge M gives COMPARE for cycles M+1..M+8, REPORT (done=1) in cycle M+9, and IDLE (ready=1) in cycle M+10.
- Timeout path: RUN lasts exactly TIMEOUT_CYCLES cycles, then REPORT, then IDLE.
- Back-to-back operation: start may be high in the first IDLE cycle after REPORT and is accepted then.

## Test plan
1. Real wrapper, msg=64'h0123456789ABCDEF, c_in=64'h0, expected=software-model digest.
   -> done pulses once, match=1, timeout=0, hash_rst low only from LAUNCH+1 through REPORT.
2. Stub wrapper returns digest 128'h0 with hash_end 5 cycles into RUN; separate runs with expected=128'h8000…0 and expected=128'h…01.
   -> done exactly 9 cycles after the hash_end sample edge; match=0 in both runs (top and bottom slices checked).
3. Stub never asserts hash_end, TIMEOUT_CYCLES=16.
   -> RUN lasts 16 cycles, then done=1 with timeout=1 and match=0; hash_rst returns to 1 in IDLE.
4. TIMEOUT_CYCLES=16, stub asserts hash_end in the 16th RUN cycle with a matching digest.
   -> completion wins: timeout=0, match=1.
5. Assert rst during the 4th COMPARE cycle.
   -> same cycle: ready=1, hash_rst=1, match=0, timeout=0, done=0; no done pulse afterwards.
6. Start with msg=A, then pulse start with msg=B during RUN.
   -> second start ignored, hash_plaintext stays A, exactly one done pulse; prior match/timeout hold until the next accepted start clears them.

Source files
------------

// File: rtl/hirose_hash_verifier.sv
// hirose_hash_verifier: consumer-side sequencer for one Hirose/PRESENT hash
// wrapper. Captures a job (message, constant, reference digest), holds the
// wrapper in reset for one launch cycle, releases it, and waits for hash_end
// under a watchdog. It then compares the digest 16 bits per cycle and reports
// match/timeout alongside a one-cycle done pulse.
//
// Handshake: a job is accepted on the rising edge where ready=1 and start=1.
// start is ignored in every other state and nothing is queued. done is high
// for exactly one cycle per accepted job that is not cut short by rst.
// match and timeout are valid from done and hold until the next accepted
// start clears them.
module hirose_hash_verifier #(
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] msg,
  input  logic [63:0]           c_in,
  input  logic [127:0]          expected,
  output logic                  ready,
  output logic                  hash_rst,
  output logic [DATA_WIDTH-1:0] hash_plaintext,
  output logic [63:0]           hash_c,
  input  logic [127:0]          hash_digest,
  input  logic                  hash_end,
  output logic                  done,
  output logic                  match,
  output logic                  timeout,
  output logic [2:0]            dbg_state
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_COMPARE = 3'd3;
  localparam logic [2:0] S_REPORT  = 3'd4;

  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [2:0]            r_state;
  logic [DATA_WIDTH-1:0] r_plaintext;
  logic [63:0]           r_c;
  logic [127:0]          r_expected;
  logic                  r_match;
  logic                  r_timeout;
  logic [CW-1:0]         r_cnt;
  logic [2:0]            r_idx;
  logic                  r_diff;

  logic [15:0]           w_dig_slice;
  logic [15:0]           w_exp_slice;
  logic                  w_diff_next;

  // Current 16-bit slice pair and the accumulated mismatch including it.
  assign w_dig_slice = hash_digest[{r_idx, 4'b0000} +: 16];
  assign w_exp_slice = r_expected[{r_idx, 4'b0000} +: 16];
  assign w_diff_next = r_diff | (w_dig_slice != w_exp_slice);

  // Handshake and wrapper-control outputs decode directly from state.
  assign ready          = (r_state == S_IDLE);
  assign hash_rst       = (r_state == S_IDLE) || (r_state == S_LAUNCH);
  assign done           = (r_state == S_REPORT);
  assign match          = r_match;
  assign timeout        = r_timeout;
  assign hash_plaintext = r_plaintext;
  assign hash_c         = r_c;
  assign dbg_state      = r_state;

  // Sequencer: job capture, launch, watchdog, slice compare and report.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_plaintext <= '0;
      r_c         <= '0;
      r_expected  <= '0;
      r_match     <= 1'b0;
      r_timeout   <= 1'b0;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_diff      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_plaintext <= msg;
            r_c         <= c_in;
            r_expected  <= expected;
            r_match     <= 1'b0;
            r_timeout   <= 1'b0;
            r_state     <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          r_cnt   <= '0;
          r_idx   <= '0;
          r_diff  <= 1'b0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          // Completion takes priority over an expiring watchdog.
          if (hash_end) begin
            r_state <= S_COMPARE;
          end else if (r_cnt == CNT_LAST) begin
            r_timeout <= 1'b1;
            r_match   <= 1'b0;
            r_state   <= S_REPORT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_COMPARE: begin
          r_diff <= w_diff_next;
          if (r_idx == 3'd7) begin
            r_match   <= ~w_diff_next;
            r_timeout <= 1'b0;
            r_state   <= S_REPORT;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_REPORT: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hirose_hash_verifier.sv
// Directed bench for hirose_hash_verifier with a behavioural wrapper stub.
// The stub raises hash_end in its Nth cycle out of reset and holds it.
// Expected match/timeout pairs are queued at each start and popped on done.
module tb_hirose_hash_verifier;

  localparam int TMO = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [63:0]  msg;
  logic [63:0]  c_in;
  logic [127:0] expected;
  logic         ready;
  logic         hash_rst;
  logic [63:0]  hash_plaintext;
  logic [63:0]  hash_c;
  logic [127:0] hash_digest;
  logic         hash_end;
  logic         done;
  logic         match;
  logic         timeout;
  logic [2:0]   dbg_state;

  hirose_hash_verifier #(.DATA_WIDTH(64), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .msg(msg), .c_in(c_in),
    .expected(expected), .ready(ready), .hash_rst(hash_rst),
    .hash_plaintext(hash_plaintext), .hash_c(hash_c),
    .hash_digest(hash_digest), .hash_end(hash_end), .done(done),
    .match(match), .timeout(timeout), .dbg_state(dbg_state)
  );

  // Clock and global time limit.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout reached");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Wrapper stub.
  logic         stub_en;
  int           stub_at;
  logic [127:0] stub_digest;
  int           stub_cnt;

  always @(posedge clk) begin
    if (hash_rst) stub_cnt <= 0;
    else if (stub_cnt < 1000) stub_cnt <= stub_cnt + 1;
  end
  assign hash_end    = stub_en && !hash_rst && (stub_cnt >= stub_at - 1);
  assign hash_digest = stub_digest;

  // Scoreboard and monitor.
  logic [1:0] exp_q[$];
  int done_count = 0;
  int done_cyc = 0;
  int he_cyc = 0;
  logic he_seen = 1'b0;
  int low_cnt = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    if (!rst) begin
      if (!hash_rst) low_cnt++;
      if (hash_end && !he_seen) begin
        he_seen = 1'b1;
        he_cyc  = cyc;
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 128'(1), 128'(0));
        end else begin
          e = exp_q.pop_front();
          chk("sb_match", 128'(match), 128'(e[1]));
          chk("sb_timeout", 128'(timeout), 128'(e[0]));
        end
      end
    end
  end

  // Driver tasks.
  task automatic do_start(input logic [63:0] m, input logic [63:0] c,
                          input logic [127:0] e, input logic en, input int at,
                          input logic [127:0] dig);
    int n;
    logic tmo;
    logic mt;
    n = 0;
    while (!ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ready) chk("ready_wait", 128'(ready), 128'(1));
    stub_en = en; stub_at = at; stub_digest = dig;
    msg = m; c_in = c; expected = e;
    start = 1'b1;
    low_cnt = 0;
    he_seen = 1'b0;
    tmo = !(en && at <= TMO);
    mt  = !tmo && (dig == e);
    exp_q.push_back({mt, tmo});
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    int d0;
    n = 0;
    d0 = done_count;
    while (done_count == d0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", 128'(done_count != d0), 128'(1));
    @(posedge clk); #1;
  endtask

  localparam logic [127:0] DIG_A = 128'hDEADBEEF_01234567_89ABCDEF_F00DCAFE;
  localparam logic [127:0] DIG_B = 128'h13579BDF_2468ACE0_0F1E2D3C_4B5A6978;

  initial begin
    int d0;
    int n;
    rst = 1'b1; start = 1'b0; msg = '0; c_in = '0; expected = '0;
    stub_en = 1'b0; stub_at = 0; stub_digest = '0;
    #1;
    chk("rst_ready", 128'(ready), 128'(1));
    chk("rst_hash_rst", 128'(hash_rst), 128'(1));
    chk("rst_done", 128'(done), 128'(0));
    chk("rst_match", 128'(match), 128'(0));
    chk("rst_timeout", 128'(timeout), 128'(0));
    chk("rst_plaintext", 128'(hash_plaintext), 128'(0));
    chk("rst_c", 128'(hash_c), 128'(0));
    chk("rst_state", 128'(dbg_state), 128'(0));
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1: matching digest after 5 RUN cycles.
    do_start(64'h0123456789ABCDEF, 64'h0, DIG_A, 1'b1, 5, DIG_A);
    chk("t1_launch_ready", 128'(ready), 128'(0));
    chk("t1_launch_hash_rst", 128'(hash_rst), 128'(1));
    chk("t1_plaintext", 128'(hash_plaintext), 128'(64'h0123456789ABCDEF));
    chk("t1_c", 128'(hash_c), 128'(0));
    @(posedge clk); #1;
    chk("t1_run_hash_rst", 128'(hash_rst), 128'(0));
    wait_done();
    chk("t1_done_latency", 128'(done_cyc - he_cyc), 128'(9));
    chk("t1_low_cycles", 128'(low_cnt), 128'(14));
    chk("t1_idle_hash_rst", 128'(hash_rst), 128'(1));

    // 2: zero digest, mismatch in top slice then in bottom slice.
    do_start(64'h1111, 64'h2222, {1'b1, 127'h0}, 1'b1, 5, 128'h0);
    wait_done();
    chk("t2a_done_latency", 128'(done_cyc - he_cyc), 128'(9));
    do_start(64'h3333, 64'h4444, 128'h1, 1'b1, 5, 128'h0);
    wait_done();
    chk("t2b_done_latency", 128'(done_cyc - he_cyc), 128'(9));

    // 3: no completion, watchdog fires after 16 RUN cycles.
    do_start(64'h5555, 64'h6666, DIG_B, 1'b0, 0, DIG_B);
    wait_done();
    chk("t3_low_cycles", 128'(low_cnt), 128'(TMO + 1));
    chk("t3_idle_hash_rst", 128'(hash_rst), 128'(1));
    repeat (3) @(posedge clk); #1;
    chk("t3_timeout_hold", 128'(timeout), 128'(1));

    // 4: completion in the last RUN cycle beats the watchdog.
    do_start(64'h7777, 64'h8888, DIG_B, 1'b1, TMO, DIG_B);
    chk("t4_cleared_timeout", 128'(timeout), 128'(0));
    wait_done();
    chk("t4_low_cycles", 128'(low_cnt), 128'(TMO + 9));

    // 5: reset in the 4th COMPARE cycle.
    do_start(64'h9999, 64'hAAAA, DIG_A, 1'b1, 5, DIG_A);
    n = 0;
    while (!hash_end && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_hash_end_seen", 128'(hash_end), 128'(1));
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("t5_ready", 128'(ready), 128'(1));
    chk("t5_hash_rst", 128'(hash_rst), 128'(1));
    chk("t5_match", 128'(match), 128'(0));
    chk("t5_timeout", 128'(timeout), 128'(0));
    chk("t5_done", 128'(done), 128'(0));
    exp_q.delete();
    d0 = done_count;
    @(posedge clk); #1 rst = 1'b0;
    repeat (30) @(posedge clk); #1;
    chk("t5_no_done", 128'(done_count), 128'(d0));

    // 6: start during RUN is ignored; results hold until next accepted start.
    do_start(64'hAAAA_0000_AAAA_0000, 64'hC0, DIG_B, 1'b1, 5, DIG_B);
    d0 = done_count;
    repeat (2) @(posedge clk); #1;
    msg = 64'hBBBB_1111_BBBB_1111;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("t6_plaintext_run", 128'(hash_plaintext), 128'(64'hAAAA_0000_AAAA_0000));
    wait_done();
    repeat (20) @(posedge clk); #1;
    chk("t6_one_done", 128'(done_count), 128'(d0 + 1));
    chk("t6_match_hold", 128'(match), 128'(1));
    chk("t6_plaintext_hold", 128'(hash_plaintext), 128'(64'hAAAA_0000_AAAA_0000));
    do_start(64'hBBBB_1111_BBBB_1111, 64'hC1, DIG_A, 1'b0, 0, DIG_A);
    chk("t6_match_cleared", 128'(match), 128'(0));
    chk("t6_plaintext_new", 128'(hash_plaintext), 128'(64'hBBBB_1111_BBBB_1111));
    wait_done();

    chk("sb_queue_empty", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
